// File: rtl/intersection_phase_scheduler_if.sv
// Sensor/lamp bundle between the intersection scheduler and its surroundings.
// The master side drives the sensor requests; the slave side (the scheduler) drives the lamps.
interface intersection_phase_scheduler_if #(
  parameter int N_APPR = 4
);
  localparam int AW = $clog2(N_APPR);

  logic [N_APPR-1:0]   req;
  logic [2*N_APPR-1:0] lights;
  logic [AW-1:0]       active;
  logic                phase_done;

  modport master (output req, input lights, input active, input phase_done);
  modport slave  (input req, output lights, output active, output phase_done);
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Round-robin green scheduler for N_APPR approaches with min/max green, yellow and all-red clearance.
// Optional emergency preemption is compiled in when EMERG_PREEMPT_EN is defined.
module intersection_phase_scheduler #(
  parameter int N_APPR    = 4,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 4
) (
  input logic clk,
  input logic rst,
  intersection_phase_scheduler_if.slave bus
`ifdef EMERG_PREEMPT_EN
  , input logic preempt
  , input logic [$clog2(N_APPR)-1:0] preempt_id
`endif
);

  localparam int AW = $clog2(N_APPR);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

  // Timer limits are "index of the last cycle", since the timer starts at 0 on phase entry.
  localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_SAT = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] Y_LIM   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(ALLRED_T - 1);

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  state_t              state, state_n;
  logic [CNT_W-1:0]    timer, timer_n, timer_inc;
  logic [AW-1:0]       ptr, ptr_n;
  logic [AW-1:0]       active_q, active_n, nxt_active, arb_base, arb_idx;
  logic [2*N_APPR-1:0] lights_q, lights_n;
  logic                done_q, done_n;
  logic                pphase, pphase_n;
  logic                arb_found, do_arb, others;
  logic [N_APPR-1:0]   act_mask;
  logic                pre_req;
  logic [AW-1:0]       pre_id;

`ifdef EMERG_PREEMPT_EN
  assign pre_req = preempt;
  assign pre_id  = preempt_id;
`else
  assign pre_req = 1'b0;
  assign pre_id  = '0;
`endif

  // First requesting approach scanning base, base+1, ... wrapping at N_APPR.
  function automatic logic [AW:0] pick(input logic [N_APPR-1:0] r, input logic [AW-1:0] base);
    logic          found;
    logic [AW-1:0] idx;
    logic [AW-1:0] jj;
    int            j;
    found = 1'b0;
    idx   = base;
    for (int i = 0; i < N_APPR; i++) begin
      j = int'(base) + i;
      if (j >= N_APPR) j = j - N_APPR;
      jj = AW'(j);
      if (!found && r[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [2*N_APPR-1:0] lamps(input state_t s, input logic [AW-1:0] a);
    logic [2*N_APPR-1:0] l;
    for (int i = 0; i < N_APPR; i++) l[2*i +: 2] = LAMP_RED;
    if (s == GREEN)  l[2*int'(a) +: 2] = LAMP_GREEN;
    if (s == YELLOW) l[2*int'(a) +: 2] = LAMP_YELLOW;
    return l;
  endfunction

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      ptr      <= '0;
      active_q <= '0;
      lights_q <= lamps(IDLE, '0);
      done_q   <= 1'b0;
      pphase   <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      ptr      <= ptr_n;
      active_q <= active_n;
      lights_q <= lights_n;
      done_q   <= done_n;
      pphase   <= pphase_n;
    end
  end

  // Next-state, timer and arbitration; the served approach drops to lowest priority at ALLRED exit.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    ptr_n      = ptr;
    active_n   = active_q;
    pphase_n   = pphase;
    done_n     = 1'b0;
    do_arb     = 1'b0;

    timer_inc  = (timer < MAX_SAT) ? timer + CNT_W'(1) : timer;
    nxt_active = (active_q == AW'(N_APPR - 1)) ? '0 : active_q + AW'(1);
    act_mask   = N_APPR'(1) << active_q;
    others     = |(bus.req & ~act_mask);
    arb_base   = (state == ALLRED && !pphase) ? nxt_active : ptr;
    {arb_found, arb_idx} = pick(bus.req, arb_base);

    case (state)
      IDLE: do_arb = 1'b1;
      GREEN: begin
        timer_n = timer_inc;
        if (pre_req && pre_id != active_q) begin
          state_n = YELLOW;
          timer_n = '0;
        end else if (!pre_req && others &&
                     ((timer >= MIN_LIM && !bus.req[active_q]) || timer >= MAX_LIM)) begin
          state_n = YELLOW;
          timer_n = '0;
        end
      end
      YELLOW: begin
        if (timer == Y_LIM) begin
          state_n = ALLRED;
          timer_n = '0;
          done_n  = (AR_LIM == '0);
        end else begin
          timer_n = timer + CNT_W'(1);
        end
      end
      ALLRED: begin
        if (timer == AR_LIM) begin
          do_arb = 1'b1;
          if (!pphase) ptr_n = nxt_active;
        end else begin
          timer_n = timer + CNT_W'(1);
          done_n  = (timer + CNT_W'(1) == AR_LIM);
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_arb) begin
      timer_n = '0;
      if (pre_req) begin
        state_n  = GREEN;
        active_n = pre_id;
        pphase_n = 1'b1;
      end else if (arb_found) begin
        state_n  = GREEN;
        active_n = arb_idx;
        pphase_n = 1'b0;
      end else begin
        state_n  = IDLE;
        pphase_n = 1'b0;
      end
    end

    lights_n = lamps(state_n, active_n);
  end

  assign bus.lights     = lights_q;
  assign bus.active     = active_q;
  assign bus.phase_done = done_q;

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Multi-approach signal scheduler that shares one intersection among N_APPR approaches. Each approach has a vehicle-sensor request line, like the single side-street sensor on the existing two-road controller. The block grants green to one approach at a time using round-robin arbitration, with min/max green timing, then yellow and all-red clearance. It drives the per-approach 2-bit lamp codes consumed by the lamp-driver layer.

Parameters:
N_APPR, 4, number of approaches (2..8)
MIN_GREEN, 4, minimum green cycles before gap-out is allowed (>=1)
MAX_GREEN, 12, green cycles after which max-out forces a change if others are waiting (>=MIN_GREEN)
YELLOW_T, 2, yellow cycles (>=1)
ALLRED_T, 1, all-red clearance cycles (>=1)
CNT_W, 4, phase timer width; must hold MAX_GREEN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  N_APPR  level sensor request per approach; bit i = approach i
lights  out  2*N_APPR  lamp code per approach at [2i+1:2i]: 2'b00 green, 2'b01 yellow, 2'b10 red (2'b11 never driven)
active  out  $clog2(N_APPR)  index of the approach currently in GREEN/YELLOW, or last served
phase_done  out  1  one-cycle pulse on the final ALLRED cycle

Behaviour:
- One clock; reset is synchronous and active-high. clk/rst as named above. All outputs are registered.
- Reset: state IDLE, every lamp red (lights = all 2'b10), active=0, phase_done=0, timer=0, rr pointer=0.
- States: IDLE, GREEN, YELLOW, ALLRED.
- Arbitration (IDLE, or exit of ALLRED): winner = first set bit of req scanning ptr, ptr+1, ... mod N_APPR.
  - Any req set: go to GREEN, active=winner, timer=0.
  - req==0: go to IDLE, all red.
- Latency: req sampled at edge k while in IDLE gives green visible on lights right after edge k.
- GREEN:
  - timer counts green cycles; it saturates at MAX_GREEN and never wraps.
  - others = OR of req excluding active.
  - Gap-out: timer has completed MIN_GREEN cycles, req[active]=0 and others=1 -> YELLOW.
  - Max-out: timer has completed MAX_GREEN cycles and others=1 -> YELLOW.
  - others=0: rest in green indefinitely, even if req[active] drops.
- YELLOW: active lamp 2'b01, all other lamps red, for exactly YELLOW_T cycles, then ALLRED.
- ALLRED: all lamps red for ALLRED_T cycles.
  - phase_done=1 on the last ALLRED cycle.
  - At exit, ptr = (active+1) mod N_APPR, then arbitrate as above.
  - The approach just served is lowest priority, so it can win again only if no other approach requests.
- Simultaneous requests are resolved only by the rr order. A req pulse shorter than the arbitration cycle is not latched and is lost.
- Invariant: at most one lamp is non-red in any cycle.
- rst mid-phase (including mid-YELLOW): next edge forces the reset values, with no yellow or clearance sequence.

Optional Feature:
EMERG_PREEMPT_EN
- Defined: adds input preempt (1) and input preempt_id ($clog2(N_APPR)).
  - preempt=1 during GREEN for active != preempt_id: YELLOW on the next edge, ignoring MIN_GREEN.
  - After YELLOW and ALLRED: GREEN for preempt_id, held while preempt=1.
  - preempt=1 with active == preempt_id: green held, max-out suppressed.
  - Preemption in IDLE or ALLRED: overrides rr arbitration.
  - Preempt phases do not update ptr.
- Not defined: ports absent; behaviour exactly as above.

Test Plan:
1. rst 3 cycles, req=0 for 20 cycles -> lights=8'b10101010, active=0, phase_done=0 throughout.
2. From IDLE, req=4'b0001 held -> approach 0 green on the next edge and held indefinitely; lights=8'b10101000.
3. req[0] held, req[2] raised at green cycle 2 -> 12 green cycles (max-out), 2 yellow, 1 all-red with phase_done pulse, then approach 2 green, active=2.
4. Approach 0 green, req[0] drops after cycle 1, req[1]=1 -> exactly 4 green cycles (gap-out), then yellow/all-red, then approach 1 green.
5. req=4'b1111 held -> green order 0,1,2,3,0; each green 12 cycles, 3 cycles between greens; never two non-red lamps.
6. rst asserted during cycle 1 of YELLOW -> next edge all red, IDLE, active=0, ptr=0; releasing with req=4'b0100 -> approach 2 green.
